i2s_master_tx: RTL
==================

// Module: i2s_master_tx
// PURPOSE
//  I2S bus master and transmitter. Derives SCLK and WS from the system clock and
//  serializes one stereo sample (left, right) per frame, MSB first, in standard I2S
//  format (one-bit WS delay). It is the driving end for the slave-mode I2S receive path
//  and feeds the DAC / codec side of the audio chain.
// PARAMETERS
//  WIDTH     16  bits per channel slot; frame = 2*WIDTH SCLK periods
//  DIV_HALF  4   clk cycles per SCLK half-period (>=1); f_sclk = f_clk/(2*DIV_HALF)
// PORTS
//  clk             in   1      system clock; single clock domain
//  rst             in   1      asynchronous, active-high reset
//  left_i          in   WIDTH  left sample, two's complement
//  right_i         in   WIDTH  right sample, two's complement
//  sample_valid_i  in   1      left_i/right_i valid this clk
//  sample_ready_o  out  1      holding register empty; transfer on valid&ready
//  sclk_out        out  1      I2S bit clock, 50% duty
//  ws_out          out  1      word select: 0 = left, 1 = right
//  sdata_out       out  1      serial data; changes on SCLK falling edge
//  frame_start_o   out  1      1-clk pulse when left MSB is launched
//  underrun_o      out  1      1-clk pulse when a frame starts with no new sample
// BEHAVIOUR
//  - Reset values: sclk_out=0, ws_out=0, sdata_out=0, frame_start_o=0, underrun_o=0,
//    sample_ready_o=1. Internal: div_cnt=0, bit_cnt=2*WIDTH-1, hold empty, last sample=0.
//  - Clock division: div_cnt counts 0..DIV_HALF-1. At terminal count it wraps and sclk_out
//    toggles. A 1->0 toggle is a "fall tick". The first rise is DIV_HALF clks after reset
//    deasserts.
//  - All serial outputs update in the same clk as the fall tick. Receivers sample on
//    SCLK rising edges.
//  - On each fall tick, bit_cnt advances (b = bit_cnt+1, wraps 2*WIDTH-1 -> 0).
//    * Bits 0..WIDTH-1 carry left, MSB first.
//    * Bits WIDTH..2*WIDTH-1 carry right, MSB first.
//    * ws_out = 1 when b is in [WIDTH-1, 2*WIDTH-2], else 0. WS therefore leads each
//      channel's MSB by one SCLK.
//  - Frame boundary (fall tick with b=0):
//    * Shift register loads {hold_l, hold_r} when hold is full. Hold empties; the pair
//      becomes the "last sample".
//    * When hold is empty, it reloads the last sample (repeat) and underrun_o pulses.
//    * sdata_out takes the frame's bit 2*WIDTH-1 in the same clk. frame_start_o pulses.
//  - Handshake: sample_ready_o = ~hold_full, registered. valid&ready captures
//    left_i/right_i into hold and sets hold_full.
//    * Capture and boundary in the same clk with hold empty: the boundary repeats the
//      last sample and flags underrun. The captured pair goes to the next frame.
//    * valid while not ready: no capture. The source must hold its data.
//  - Reset mid-frame: all state returns to reset values immediately. The partial frame
//    is abandoned. The held sample is discarded.
//  - No arithmetic on sample data. Samples are transmitted bit-exact.
// STRUCTURE
//  - i2s_pkg: WIDTH default, I2S_WS_LEFT/I2S_WS_RIGHT constants, and
//    typedef logic [WIDTH-1:0] sample_t. Shared with the receive path.
//  - Sub-module i2s_clk_div (DIV_HALF): outputs sclk_out, rise_tick, fall_tick.
//  - The top holds the bit counter, shift register, hold register and flags.
// TESTING (WIDTH=16, DIV_HALF=2; SCLK period = 4 clk, frame = 128 clk)
//  1 Reset held 10 clk, then released -> all outputs 0, ready=1; first sclk rise 2 clk
//    after release; period 4 clk, duty 50%.
//  2 Push L=16'hA5C3, R=16'h0F01 before the first boundary -> a slave model sampling on
//    sclk rise recovers A5C3 (ws=0) and 0F01 (ws=1); no underrun_o.
//  3 WS alignment -> ws rises on the fall tick carrying L bit0. Right MSB follows one
//    SCLK later. ws falls on R bit0.
//  4 No push for frame 2 after L=16'h8001, R=16'h7FFE -> underrun_o single pulse at
//    frame_start_o; frame 2 repeats 8001/7FFE.
//  5 Two back-to-back pushes 1111/2222 then 3333/4444 -> ready drops after the first
//    push. The second push is accepted only after the next frame_start_o. Frames carry
//    1111/2222 then 3333/4444 in order.
//  6 Assert rst at bit 20 of a frame -> outputs 0 in the same clk, not on the next edge.
//    After release the bench pushes a new sample; the first frame_start_o follows and
//    the bench sees no stale data.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmit master and the slave-mode receive path.
package i2s_pkg;

   localparam int unsigned I2S_WIDTH    = 16;
   localparam logic        I2S_WS_LEFT  = 1'b0;
   localparam logic        I2S_WS_RIGHT = 1'b1;

   typedef logic [I2S_WIDTH-1:0] sample_t;

   typedef struct packed {
      sample_t left;
      sample_t right;
   } stereo_t;

endpackage

// File: rtl/i2s_master_tx_if.sv
// Stereo sample handshake between an audio source and the I2S transmitter.
interface i2s_master_tx_if
   import i2s_pkg::*;
#(
   parameter int unsigned WIDTH = I2S_WIDTH
);
   logic [WIDTH-1:0] left_i;
   logic [WIDTH-1:0] right_i;
   logic             sample_valid_i;
   logic             sample_ready_o;

   modport master (output left_i, output right_i, output sample_valid_i, input sample_ready_o);
   modport slave  (input left_i, input right_i, input sample_valid_i, output sample_ready_o);
endinterface

// File: rtl/i2s_clk_div.sv
// SCLK generator: toggles every DIV_HALF clk cycles and flags the edge about to happen.
module i2s_clk_div
   import i2s_pkg::*;
#(
   parameter int unsigned DIV_HALF = 4
) (
   input  logic clk,
   input  logic rst,
   output logic sclk_out,
   output logic rise_tick_c,
   output logic fall_tick_c
);
   localparam int unsigned CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

   logic [CW-1:0] r_div_cnt;
   logic          r_sclk;
   logic          w_term;

   assign w_term      = (r_div_cnt == CW'(DIV_HALF - 1));
   assign rise_tick_c = w_term & ~r_sclk;
   assign fall_tick_c = w_term & r_sclk;
   assign sclk_out    = r_sclk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_sclk    <= 1'b0;
      end else if (w_term) begin
         r_div_cnt <= '0;
         r_sclk    <= ~r_sclk;
      end else begin
         r_div_cnt <= r_div_cnt + CW'(1);
      end
   end
endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: generates SCLK/WS and shifts out one stereo sample per frame,
// MSB first with the one-bit WS delay; repeats the previous sample on underrun.
module i2s_master_tx
   import i2s_pkg::*;
#(
   parameter int unsigned WIDTH    = I2S_WIDTH,
   parameter int unsigned DIV_HALF = 4
) (
   input  logic           clk,
   input  logic           rst,
   i2s_master_tx_if.slave s_if,
   output logic           sclk_out,
   output logic           ws_out,
   output logic           sdata_out,
   output logic           frame_start_o,
   output logic           underrun_o
);
   localparam int unsigned FW = 2 * WIDTH;
   localparam int unsigned BW = $clog2(FW);

   logic          w_rise_tick;
   logic          w_fall_tick;
   logic [BW-1:0] r_bit_cnt, w_bit_cnt_n, w_b;
   logic [FW-1:0] r_shift, w_shift_n;
   logic [FW-1:0] r_hold, w_hold_n;
   logic [FW-1:0] r_last, w_last_n;
   logic [FW-1:0] w_frame;
   logic          r_hold_full, w_hold_full_n;
   logic          r_ready, w_ready_n;
   logic          r_ws, w_ws_n;
   logic          r_sdata, w_sdata_n;
   logic          r_frame_start, w_frame_start_n;
   logic          r_underrun, w_underrun_n;

   i2s_clk_div #(.DIV_HALF(DIV_HALF)) u_clk_div (
      .clk         (clk),
      .rst         (rst),
      .sclk_out    (sclk_out),
      .rise_tick_c (w_rise_tick),
      .fall_tick_c (w_fall_tick)
   );

   // The divider can never announce both SCLK edges in one clk.
   assert property (@(posedge clk) disable iff (rst) !(w_rise_tick && w_fall_tick));

   always_comb begin
      w_bit_cnt_n     = r_bit_cnt;
      w_shift_n       = r_shift;
      w_hold_n        = r_hold;
      w_last_n        = r_last;
      w_hold_full_n   = r_hold_full;
      w_ws_n          = r_ws;
      w_sdata_n       = r_sdata;
      w_frame_start_n = 1'b0;
      w_underrun_n    = 1'b0;
      w_b             = (r_bit_cnt == BW'(FW - 1)) ? '0 : r_bit_cnt + BW'(1);
      w_frame         = r_hold_full ? r_hold : r_last;

      if (w_fall_tick) begin
         w_bit_cnt_n = w_b;
         w_ws_n      = (w_b >= BW'(WIDTH - 1) && w_b <= BW'(FW - 2)) ? I2S_WS_RIGHT : I2S_WS_LEFT;
         if (w_b == '0) begin
            w_shift_n       = w_frame;
            w_sdata_n       = w_frame[FW-1];
            w_last_n        = w_frame;
            w_frame_start_n = 1'b1;
            w_underrun_n    = ~r_hold_full;
            w_hold_full_n   = 1'b0;
         end else begin
            w_shift_n = r_shift << 1;
            w_sdata_n = r_shift[FW-2];
         end
      end

      // A capture coinciding with an empty-hold boundary lands in the following frame.
      if (s_if.sample_valid_i && r_ready) begin
         w_hold_n      = {s_if.left_i, s_if.right_i};
         w_hold_full_n = 1'b1;
      end

      w_ready_n = ~w_hold_full_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt     <= BW'(FW - 1);
         r_shift       <= '0;
         r_hold        <= '0;
         r_last        <= '0;
         r_hold_full   <= 1'b0;
         r_ready       <= 1'b1;
         r_ws          <= I2S_WS_LEFT;
         r_sdata       <= 1'b0;
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_bit_cnt     <= w_bit_cnt_n;
         r_shift       <= w_shift_n;
         r_hold        <= w_hold_n;
         r_last        <= w_last_n;
         r_hold_full   <= w_hold_full_n;
         r_ready       <= w_ready_n;
         r_ws          <= w_ws_n;
         r_sdata       <= w_sdata_n;
         r_frame_start <= w_frame_start_n;
         r_underrun    <= w_underrun_n;
      end
   end

   assign s_if.sample_ready_o = r_ready;
   assign ws_out              = r_ws;
   assign sdata_out           = r_sdata;
   assign frame_start_o       = r_frame_start;
   assign underrun_o          = r_underrun;
endmodule
